// File: rtl/decode_stage.sv
// RV32I decode stage: field/immediate decode, 32x32 register file, scoreboard RAW stalls,
// and a single output register feeding execute.
module decode_stage #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 32,
   parameter int REG_AW     = 5
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  fetch_valid_i,
   input  logic [ADDR_WIDTH-1:0] fetch_pc_i,
   input  logic [DATA_WIDTH-1:0] fetch_instr_i,
   output logic                  fetch_stall_o,
   input  logic                  flush_i,
   input  logic                  ex_stall_i,
   output logic                  ex_valid_o,
   output logic [ADDR_WIDTH-1:0] ex_pc_o,
   output logic [DATA_WIDTH-1:0] ex_rs1_data_o,
   output logic [DATA_WIDTH-1:0] ex_rs2_data_o,
   output logic [DATA_WIDTH-1:0] ex_imm_o,
   output logic [REG_AW-1:0]     ex_rd_o,
   output logic [6:0]            ex_opcode_o,
   output logic [2:0]            ex_funct3_o,
   output logic [6:0]            ex_funct7_o,
   output logic                  ex_writes_rd_o,
   output logic                  ex_is_load_o,
   output logic                  ex_is_store_o,
   output logic                  ex_is_branch_o,
   output logic                  ex_is_jump_o,
   output logic                  ex_illegal_o,
   input  logic                  wb_valid_i,
   input  logic [REG_AW-1:0]     wb_rd_i,
   input  logic                  wb_we_i,
   input  logic [DATA_WIDTH-1:0] wb_data_i
);

   logic [DATA_WIDTH-1:0] rf [NUM_REGS];
   logic [NUM_REGS-1:0]   scoreboard;

   logic [DATA_WIDTH-1:0] inst;
   logic [6:0]            opcode;
   logic [REG_AW-1:0]     rd, rs1, rs2;
   assign inst   = fetch_instr_i;
   assign opcode = inst[6:0];
   assign rd     = inst[11:7];
   assign rs1    = inst[19:15];
   assign rs2    = inst[24:20];

   logic                  uses_rs1, uses_rs2, writes_rd, is_load, is_store, is_branch, is_jump, illegal;
   logic [DATA_WIDTH-1:0] imm;

   always_comb begin
      uses_rs1  = 1'b0;
      uses_rs2  = 1'b0;
      writes_rd = 1'b0;
      is_load   = 1'b0;
      is_store  = 1'b0;
      is_branch = 1'b0;
      is_jump   = 1'b0;
      illegal   = 1'b0;
      imm       = '0;
      case (opcode)
         7'h33: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes_rd = 1'b1; end
         7'h13: begin uses_rs1 = 1'b1; writes_rd = 1'b1;
                      imm = {{(DATA_WIDTH-12){inst[31]}}, inst[31:20]}; end
         7'h03: begin uses_rs1 = 1'b1; writes_rd = 1'b1; is_load = 1'b1;
                      imm = {{(DATA_WIDTH-12){inst[31]}}, inst[31:20]}; end
         7'h67: begin uses_rs1 = 1'b1; writes_rd = 1'b1; is_jump = 1'b1;
                      imm = {{(DATA_WIDTH-12){inst[31]}}, inst[31:20]}; end
         7'h23: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; is_store = 1'b1;
                      imm = {{(DATA_WIDTH-12){inst[31]}}, inst[31:25], inst[11:7]}; end
         7'h63: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; is_branch = 1'b1;
                      imm = {{(DATA_WIDTH-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}; end
         7'h37, 7'h17: begin writes_rd = 1'b1; imm = {inst[31:12], 12'b0}; end
         7'h6F: begin writes_rd = 1'b1; is_jump = 1'b1;
                      imm = {{(DATA_WIDTH-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}; end
         default: illegal = 1'b1;
      endcase
      if (rd == '0) writes_rd = 1'b0;
   end

   // Source is busy if an older writer is pending in the scoreboard (and not retiring now)
   // or is still sitting in the output register, not yet recorded.
   logic rf_we, rs1_busy, rs2_busy, raw_hazard, occupied_blocked;
   assign rf_we    = wb_valid_i && wb_we_i && (wb_rd_i != '0);
   assign rs1_busy = (rs1 != '0) &&
                     ((scoreboard[rs1] && !(wb_valid_i && wb_rd_i == rs1)) ||
                      (ex_valid_o && ex_writes_rd_o && ex_rd_o == rs1));
   assign rs2_busy = (rs2 != '0) &&
                     ((scoreboard[rs2] && !(wb_valid_i && wb_rd_i == rs2)) ||
                      (ex_valid_o && ex_writes_rd_o && ex_rd_o == rs2));
   assign raw_hazard       = (uses_rs1 && rs1_busy) || (uses_rs2 && rs2_busy);
   assign occupied_blocked = ex_valid_o && ex_stall_i;
   assign fetch_stall_o    = !flush_i && fetch_valid_i && (occupied_blocked || raw_hazard);

   logic fetch_acc, ex_acc;
   assign fetch_acc = fetch_valid_i && !fetch_stall_o && !flush_i;
   assign ex_acc    = ex_valid_o && !ex_stall_i && !flush_i;

   logic [DATA_WIDTH-1:0] rs1_val, rs2_val;
   assign rs1_val = (rs1 == '0) ? '0 : (rf_we && wb_rd_i == rs1) ? wb_data_i : rf[rs1];
   assign rs2_val = (rs2 == '0) ? '0 : (rf_we && wb_rd_i == rs2) ? wb_data_i : rf[rs2];

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
      end else if (rf_we) begin
         rf[wb_rd_i] <= wb_data_i;
      end
   end

   // Clear first so a same-index set from a newer instruction wins.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         scoreboard <= '0;
      end else begin
         logic [NUM_REGS-1:0] sb_n;
         sb_n = scoreboard;
         if (wb_valid_i) sb_n[wb_rd_i] = 1'b0;
         if (ex_acc && ex_writes_rd_o) sb_n[ex_rd_o] = 1'b1;
         scoreboard <= sb_n;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ex_valid_o     <= 1'b0;
         ex_pc_o        <= '0;
         ex_rs1_data_o  <= '0;
         ex_rs2_data_o  <= '0;
         ex_imm_o       <= '0;
         ex_rd_o        <= '0;
         ex_opcode_o    <= '0;
         ex_funct3_o    <= '0;
         ex_funct7_o    <= '0;
         ex_writes_rd_o <= 1'b0;
         ex_is_load_o   <= 1'b0;
         ex_is_store_o  <= 1'b0;
         ex_is_branch_o <= 1'b0;
         ex_is_jump_o   <= 1'b0;
         ex_illegal_o   <= 1'b0;
      end else if (flush_i) begin
         ex_valid_o <= 1'b0;
      end else if (fetch_acc) begin
         ex_valid_o     <= 1'b1;
         ex_pc_o        <= fetch_pc_i;
         ex_rs1_data_o  <= rs1_val;
         ex_rs2_data_o  <= rs2_val;
         ex_imm_o       <= imm;
         ex_rd_o        <= rd;
         ex_opcode_o    <= opcode;
         ex_funct3_o    <= inst[14:12];
         ex_funct7_o    <= inst[31:25];
         ex_writes_rd_o <= writes_rd;
         ex_is_load_o   <= is_load;
         ex_is_store_o  <= is_store;
         ex_is_branch_o <= is_branch;
         ex_is_jump_o   <= is_jump;
         ex_illegal_o   <= illegal;
      end else if (ex_acc) begin
         ex_valid_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode, RAW stalls, backpressure, flush and reset.
module tb_decode_stage;
   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        fetch_valid_i, flush_i, ex_stall_i;
   logic [31:0] fetch_pc_i, fetch_instr_i;
   logic        fetch_stall_o, ex_valid_o;
   logic [31:0] ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
   logic [4:0]  ex_rd_o;
   logic [6:0]  ex_opcode_o, ex_funct7_o;
   logic [2:0]  ex_funct3_o;
   logic        ex_writes_rd_o, ex_is_load_o, ex_is_store_o, ex_is_branch_o, ex_is_jump_o, ex_illegal_o;
   logic        wb_valid_i, wb_we_i;
   logic [4:0]  wb_rd_i;
   logic [31:0] wb_data_i;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk_i = ~clk_i;

   decode_stage dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .fetch_valid_i(fetch_valid_i), .fetch_pc_i(fetch_pc_i), .fetch_instr_i(fetch_instr_i),
      .fetch_stall_o(fetch_stall_o), .flush_i(flush_i), .ex_stall_i(ex_stall_i),
      .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o), .ex_rs1_data_o(ex_rs1_data_o),
      .ex_rs2_data_o(ex_rs2_data_o), .ex_imm_o(ex_imm_o), .ex_rd_o(ex_rd_o),
      .ex_opcode_o(ex_opcode_o), .ex_funct3_o(ex_funct3_o), .ex_funct7_o(ex_funct7_o),
      .ex_writes_rd_o(ex_writes_rd_o), .ex_is_load_o(ex_is_load_o), .ex_is_store_o(ex_is_store_o),
      .ex_is_branch_o(ex_is_branch_o), .ex_is_jump_o(ex_is_jump_o), .ex_illegal_o(ex_illegal_o),
      .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .wb_we_i(wb_we_i), .wb_data_i(wb_data_i)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic feed(input logic [31:0] pc, input logic [31:0] ins);
      fetch_valid_i = 1'b1;
      fetch_pc_i    = pc;
      fetch_instr_i = ins;
   endtask

   function automatic logic [4:0] flags();
      return {ex_writes_rd_o, ex_is_load_o, ex_is_store_o, ex_is_branch_o, ex_is_jump_o};
   endfunction

   initial begin
      rst_i = 1'b0; fetch_valid_i = 1'b0; flush_i = 1'b0; ex_stall_i = 1'b0;
      fetch_pc_i = '0; fetch_instr_i = '0;
      wb_valid_i = 1'b0; wb_we_i = 1'b0; wb_rd_i = '0; wb_data_i = '0;
      #12;
      check("rst_valid", {31'b0, ex_valid_o}, 32'h0);
      check("rst_imm", ex_imm_o, 32'h0);
      check("rst_stall", {31'b0, fetch_stall_o}, 32'h0);
      check("rst_sb", dut.scoreboard, 32'h0);
      rst_i = 1'b1;
      tick();

      // addi x1,x0,5
      feed(32'h1000, 32'h00500093);
      #1 check("addi_stall", {31'b0, fetch_stall_o}, 32'h0);
      tick();
      check("addi_valid", {31'b0, ex_valid_o}, 32'h1);
      check("addi_pc", ex_pc_o, 32'h1000);
      check("addi_rd", {27'b0, ex_rd_o}, 32'h1);
      check("addi_imm", ex_imm_o, 32'h5);
      check("addi_wr", {31'b0, ex_writes_rd_o}, 32'h1);

      // add x2,x1,x1: blocked by x1 in the output register, then by the scoreboard
      feed(32'h1004, 32'h00108133);
      #1 check("add_stall_ex", {31'b0, fetch_stall_o}, 32'h1);
      tick();
      check("add_sb1_set", {31'b0, dut.scoreboard[1]}, 32'h1);
      check("add_ex_empty", {31'b0, ex_valid_o}, 32'h0);
      check("add_stall_sb", {31'b0, fetch_stall_o}, 32'h1);
      tick();
      check("add_stall_sb2", {31'b0, fetch_stall_o}, 32'h1);
      wb_valid_i = 1'b1; wb_we_i = 1'b1; wb_rd_i = 5'd1; wb_data_i = 32'd5;
      #1 check("add_stall_wb", {31'b0, fetch_stall_o}, 32'h0);
      tick();
      wb_valid_i = 1'b0; wb_we_i = 1'b0;
      check("add_valid", {31'b0, ex_valid_o}, 32'h1);
      check("add_rs1", ex_rs1_data_o, 32'd5);
      check("add_rs2", ex_rs2_data_o, 32'd5);
      check("add_rd", {27'b0, ex_rd_o}, 32'h2);
      check("add_sb1_clr", {31'b0, dut.scoreboard[1]}, 32'h0);

      // beq x0,x0,-4
      feed(32'h1008, 32'hFE000EE3);
      #1 check("beq_stall", {31'b0, fetch_stall_o}, 32'h0);
      tick();
      check("beq_pc", ex_pc_o, 32'h1008);
      check("beq_imm", ex_imm_o, 32'hFFFFFFFC);
      check("beq_flags", {27'b0, flags()}, 32'h02);
      check("beq_sb2", {31'b0, dut.scoreboard[2]}, 32'h1);

      // lui x5,0x12345
      feed(32'h100C, 32'h123452B7);
      tick();
      check("lui_imm", ex_imm_o, 32'h12345000);
      check("lui_rd", {27'b0, ex_rd_o}, 32'h5);
      check("lui_flags", {27'b0, flags()}, 32'h10);

      // Backpressure: addi x3,x0,7 waits behind the held lui
      ex_stall_i = 1'b1;
      feed(32'h1010, 32'h00700193);
      #1 check("bp_stall", {31'b0, fetch_stall_o}, 32'h1);
      tick();
      check("bp_hold_pc", ex_pc_o, 32'h100C);
      check("bp_hold_imm", ex_imm_o, 32'h12345000);
      check("bp_stall2", {31'b0, fetch_stall_o}, 32'h1);
      ex_stall_i = 1'b0;
      #1 check("bp_release", {31'b0, fetch_stall_o}, 32'h0);
      tick();
      check("bp_new_pc", ex_pc_o, 32'h1010);
      check("bp_new_imm", ex_imm_o, 32'h7);
      check("bp_sb5", {31'b0, dut.scoreboard[5]}, 32'h1);

      // Flush with addi x4 presented: dropped, scoreboard keeps {x2,x5}
      flush_i = 1'b1;
      feed(32'h1014, 32'h00A00213);
      #1 check("fl_stall", {31'b0, fetch_stall_o}, 32'h0);
      tick();
      flush_i = 1'b0;
      fetch_valid_i = 1'b0;
      check("fl_valid", {31'b0, ex_valid_o}, 32'h0);
      check("fl_sb", dut.scoreboard, 32'h00000024);

      // Retire x5 without a write: scoreboard clears, register file untouched
      wb_valid_i = 1'b1; wb_we_i = 1'b0; wb_rd_i = 5'd5; wb_data_i = 32'hDEADBEEF;
      tick();
      wb_valid_i = 1'b0;
      check("wbn_sb", dut.scoreboard, 32'h00000004);
      check("wbn_rf", dut.rf[5], 32'h0);

      // Illegal opcode
      feed(32'h1018, 32'h00000000);
      tick();
      fetch_valid_i = 1'b0;
      check("ill_valid", {31'b0, ex_valid_o}, 32'h1);
      check("ill_flag", {31'b0, ex_illegal_o}, 32'h1);
      check("ill_flags", {27'b0, flags()}, 32'h0);

      // Asynchronous reset mid-cycle while execute stalls
      ex_stall_i = 1'b1;
      #2 rst_i = 1'b0;
      #1 check("arst_valid", {31'b0, ex_valid_o}, 32'h0);
      check("arst_ill", {31'b0, ex_illegal_o}, 32'h0);
      check("arst_sb", dut.scoreboard, 32'h0);
      check("arst_rf1", dut.rf[1], 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipeline stage directly downstream of the fetch stage. It accepts one instruction per handshake from fetch and decodes RV32I fields and immediates.
- It reads operands from an internal 32x32 register file and applies scoreboard-based RAW hazard stalls.
- It holds the decoded instruction in a single output register for the execute stage, and backpressures fetch through a combinational stall.
- Writeback from the later stages updates the register file and releases scoreboard entries.

Parameters:
- ADDR_WIDTH, 32, PC width.
- DATA_WIDTH, 32, instruction and register width.
- NUM_REGS, 32, architectural register count; x0 is hardwired to zero.
- REG_AW, 5, register index width, equal to log2(NUM_REGS).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-low.
- fetch_valid_i  in  1  instruction from fetch is valid.
- fetch_pc_i  in  ADDR_WIDTH  PC of that instruction.
- fetch_instr_i  in  DATA_WIDTH  instruction word.
- fetch_stall_o  out  1  fetch must hold its current instruction; combinational.
- flush_i  in  1  branch-taken or jump redirect from execute.
- ex_stall_i  in  1  execute cannot accept this cycle.
- ex_valid_o  out  1  output register holds a valid instruction.
- ex_pc_o  out  ADDR_WIDTH  PC of the held instruction.
- ex_rs1_data_o, ex_rs2_data_o  out  DATA_WIDTH  operand values.
- ex_imm_o  out  DATA_WIDTH  sign-extended immediate.
- ex_rd_o  out  REG_AW  destination register.
- ex_opcode_o  out  7  opcode field.
- ex_funct3_o  out  3  funct3 field.
- ex_funct7_o  out  7  funct7 field.
- ex_writes_rd_o, ex_is_load_o, ex_is_store_o, ex_is_branch_o, ex_is_jump_o, ex_illegal_o  out  1 each  control flags.
- wb_valid_i  in  1  retirement of one instruction previously issued to execute.
- wb_rd_i  in  REG_AW  destination of the retiring instruction.
- wb_we_i  in  1  write wb_data_i to the register file.
- wb_data_i  in  DATA_WIDTH  writeback value.

Behaviour:

Reset (rst_i low, asynchronous):
- ex_valid_o=0; all ex_* data and control outputs are 0.
- Scoreboard is all 0.
- All registers are 0.
- Reset mid-stall discards the held instruction.

Handshakes:
- Fetch accept: fetch_valid_i && !fetch_stall_o && !flush_i. The decoded result is registered into the output register on that clock edge, so latency is 1 cycle.
- Execute accept: ex_valid_o && !ex_stall_i && !flush_i. On accept, the output register is refilled by a simultaneous fetch accept, or otherwise clears ex_valid_o.

Stall:
- fetch_stall_o = !flush_i && fetch_valid_i && (occupied_blocked || raw_hazard).
- occupied_blocked = ex_valid_o && ex_stall_i.
- raw_hazard applies when any source register rsN the incoming instruction uses is nonzero and either:
  - scoreboard[rsN] is set and is not being cleared this cycle, or
  - ex_valid_o && ex_writes_rd_o && ex_rd_o==rsN.

Decode:
- Source use:
  - uses_rs1 for opcodes 0x33, 0x13, 0x03, 0x23, 0x63, 0x67.
  - uses_rs2 for opcodes 0x33, 0x23, 0x63.
- writes_rd for opcodes 0x33, 0x13, 0x03, 0x37, 0x17, 0x6F, 0x67, and only when rd!=0.
- Immediate formats:
  - I (0x13, 0x03, 0x67): inst[31:20] sign-extended.
  - S (0x23): {inst[31:25], inst[11:7]} sign-extended.
  - B (0x63): {inst[31], inst[7], inst[30:25], inst[11:8], 0} sign-extended.
  - U (0x37, 0x17): {inst[31:12], 12'b0}.
  - J (0x6F): {inst[31], inst[19:12], inst[20], inst[30:21], 0} sign-extended.
  - R-type: 0.
- Any other opcode sets illegal=1 and clears all other control flags; it still passes down with ex_valid_o=1.

Register file:
- Write on wb_valid_i && wb_we_i && wb_rd_i!=0.
- A read of x0 returns 0.
- Same-cycle write and read of the same register bypasses, i.e. the new data is captured.

Scoreboard:
- scoreboard[ex_rd_o] is set on execute accept when ex_writes_rd_o.
- scoreboard[wb_rd_i] is cleared on wb_valid_i, whether or not wb_we_i is set.
- Simultaneous set and clear of the same index leaves it set, because the set belongs to a newer instruction.
- Execute must still retire, with wb_we_i=0, any instruction it kills, so the scoreboard never leaks.

Flush:
- Output register is invalidated on the next edge (ex_valid_o=0).
- No execute accept occurs that cycle and the scoreboard is not set.
- Incoming fetch data is dropped and fetch_stall_o=0.
- The scoreboard is otherwise untouched.

Test Plan:
- Reset, then feed 0x00500093 (addi x1,x0,5) at PC 0x1000 with ex_stall_i=0 -> next cycle: ex_valid_o=1, ex_pc_o=0x1000, ex_rd_o=1, ex_imm_o=5, ex_writes_rd_o=1; after accept, scoreboard[1]=1.
- Feed 0x00108133 (add x2,x1,x1) right after that addi -> fetch_stall_o=1 until wb_valid_i with wb_rd_i=1, wb_we_i=1, wb_data_i=5. In that wb cycle the stall drops, and the following cycle ex_rs1_data_o = ex_rs2_data_o = 5.
- Feed 0xFE000EE3 (beq x0,x0,-4) -> ex_is_branch_o=1, ex_imm_o=0xFFFFFFFC, ex_writes_rd_o=0, no stall. Feed 0x123452B7 (lui x5) -> ex_imm_o=0x12345000, ex_rd_o=5.
- Hold ex_stall_i=1 while ex_valid_o=1 and a new instruction is presented -> fetch_stall_o=1 and outputs stay stable. Release ex_stall_i -> the held instruction is accepted and the new one is captured on the same edge.
- With ex_valid_o=1, assert flush_i with a fetch instruction present -> next cycle ex_valid_o=0, that cycle fetch_stall_o=0, and the scoreboard is unchanged.
- Feed 0x00000000 -> ex_illegal_o=1, all other control flags 0, ex_valid_o=1. Then assert rst_i low mid-cycle -> ex_valid_o=0 immediately.
